// File: rtl/uart_boot_loader.sv
// Purpose: receives a framed program image over UART, writes it into instruction memory and holds the core in reset until the checksum verifies.
// Latency: each memory write strobes one cycle after the stop bit of a word's 4th byte is sampled; o_done rises one cycle after the CHK stop bit is sampled.
// Backpressure: none; the UART sets the pace and the memory port must take one write per strobe.
// Ports: i_clk/i_reset_n (sync, active-low), i_rx (async UART line, idle high),
//        o_imemWrEn/o_imemAddr/o_imemWrData (instruction-memory write port),
//        o_core_reset_n (core reset), o_busy/o_done/o_error (loader status).
module uart_boot_loader #(
   parameter int          CLKS_PER_BIT = 868,
   parameter int          ADDR_WIDTH   = 10,
   parameter logic [7:0]  MAGIC        = 8'hB5,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_rx,
   output logic        o_imemWrEn,
   output logic [31:0] o_imemAddr,
   output logic [31:0] o_imemWrData,
   output logic        o_core_reset_n,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error
);

   localparam int              CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   CNT_FULL  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [31:0]     MAX_WORDS = 32'd1 << ADDR_WIDTH;

   // ---------------- RX front end ----------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t     rx_state, rx_state_nxt;
   logic          rx_s1, rx_s2, rx_d;
   logic [CW-1:0] clk_cnt, clk_cnt_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    rx_shift, rx_shift_nxt;
   logic          byte_valid, frame_err;

   // rx_d is a third tap used only for edge detection, so a stop bit that
   // was held low does not immediately look like a new start bit.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_d     <= 1'b1;
         rx_state <= RX_IDLE;
         clk_cnt  <= '0;
         bit_idx  <= '0;
         rx_shift <= '0;
      end else begin
         rx_s1    <= i_rx;
         rx_s2    <= rx_s1;
         rx_d     <= rx_s2;
         rx_state <= rx_state_nxt;
         clk_cnt  <= clk_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         rx_shift <= rx_shift_nxt;
      end
   end

   always_comb begin
      rx_state_nxt = rx_state;
      clk_cnt_nxt  = clk_cnt;
      bit_idx_nxt  = bit_idx;
      rx_shift_nxt = rx_shift;
      byte_valid   = 1'b0;
      frame_err    = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            clk_cnt_nxt = '0;
            if (rx_d && !rx_s2) rx_state_nxt = RX_START;
         end
         RX_START: begin
            if (clk_cnt == CNT_HALF) begin
               // Line back high at mid start bit: glitch, not a byte.
               clk_cnt_nxt  = '0;
               bit_idx_nxt  = '0;
               rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
               clk_cnt_nxt = clk_cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (clk_cnt == CNT_FULL) begin
               clk_cnt_nxt  = '0;
               rx_shift_nxt = {rx_s2, rx_shift[7:1]};
               bit_idx_nxt  = bit_idx + 3'd1;
               if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
            end else begin
               clk_cnt_nxt = clk_cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (clk_cnt == CNT_FULL) begin
               clk_cnt_nxt  = '0;
               rx_state_nxt = RX_IDLE;
               byte_valid   = rx_s2;
               frame_err    = !rx_s2;
            end else begin
               clk_cnt_nxt = clk_cnt + 1'b1;
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   // ---------------- Loader ----------------
   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERROR} ld_state_t;

   ld_state_t   ld_state, ld_state_nxt;
   logic [7:0]  len_lo, len_lo_nxt;
   logic [15:0] len, len_nxt;
   logic [15:0] idx, idx_nxt;
   logic [1:0]  lane, lane_nxt;
   logic [23:0] word, word_nxt;    // lanes 0..2; lane 3 arrives with the write
   logic [7:0]  chk, chk_nxt;
   logic        wr_en, wr_en_nxt;
   logic [31:0] wr_addr, wr_addr_nxt;
   logic [31:0] wr_data, wr_data_nxt;
   logic [15:0] n_words;

   assign n_words = {rx_shift, len_lo};

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         ld_state <= IDLE;
         len_lo   <= '0;
         len      <= '0;
         idx      <= '0;
         lane     <= '0;
         word     <= '0;
         chk      <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= BASE_ADDR;
         wr_data  <= '0;
      end else begin
         ld_state <= ld_state_nxt;
         len_lo   <= len_lo_nxt;
         len      <= len_nxt;
         idx      <= idx_nxt;
         lane     <= lane_nxt;
         word     <= word_nxt;
         chk      <= chk_nxt;
         wr_en    <= wr_en_nxt;
         wr_addr  <= wr_addr_nxt;
         wr_data  <= wr_data_nxt;
      end
   end

   always_comb begin
      ld_state_nxt = ld_state;
      len_lo_nxt   = len_lo;
      len_nxt      = len;
      idx_nxt      = idx;
      lane_nxt     = lane;
      word_nxt     = word;
      chk_nxt      = chk;
      wr_en_nxt    = 1'b0;
      wr_addr_nxt  = wr_addr;
      wr_data_nxt  = wr_data;
      case (ld_state)
         // frame_err is ignored while waiting for a frame start.
         IDLE, ERROR: begin
            if (byte_valid && rx_shift == MAGIC) begin
               ld_state_nxt = LEN0;
               chk_nxt      = '0;
               idx_nxt      = '0;
               lane_nxt     = '0;
            end
         end
         LEN0: begin
            if (frame_err) begin
               ld_state_nxt = ERROR;
            end else if (byte_valid) begin
               len_lo_nxt   = rx_shift;
               chk_nxt      = chk ^ rx_shift;
               ld_state_nxt = LEN1;
            end
         end
         LEN1: begin
            if (frame_err) begin
               ld_state_nxt = ERROR;
            end else if (byte_valid) begin
               len_nxt  = n_words;
               chk_nxt  = chk ^ rx_shift;
               idx_nxt  = '0;
               lane_nxt = '0;
               if ({16'd0, n_words} > MAX_WORDS) ld_state_nxt = ERROR;
               else if (n_words == 16'd0)        ld_state_nxt = CHECK;
               else                              ld_state_nxt = DATA;
            end
         end
         DATA: begin
            if (frame_err) begin
               ld_state_nxt = ERROR;
            end else if (byte_valid) begin
               chk_nxt  = chk ^ rx_shift;
               word_nxt = {rx_shift, word[23:8]};
               lane_nxt = lane + 2'd1;
               if (lane == 2'd3) begin
                  wr_en_nxt   = 1'b1;
                  wr_addr_nxt = BASE_ADDR + {14'd0, idx, 2'b00};
                  wr_data_nxt = {rx_shift, word};
                  idx_nxt     = idx + 16'd1;
                  if (idx == len - 16'd1) ld_state_nxt = CHECK;
               end
            end
         end
         CHECK: begin
            if (frame_err) begin
               ld_state_nxt = ERROR;
            end else if (byte_valid) begin
               ld_state_nxt = (rx_shift == chk) ? DONE : ERROR;
            end
         end
         DONE: ld_state_nxt = DONE;   // sticky until reset; UART free for reuse
         default: ld_state_nxt = IDLE;
      endcase
   end

   assign o_imemWrEn     = wr_en;
   assign o_imemAddr     = wr_addr;
   assign o_imemWrData   = wr_data;
   assign o_done         = (ld_state == DONE);
   assign o_core_reset_n = (ld_state == DONE);
   assign o_error        = (ld_state == ERROR);
   assign o_busy         = ld_state inside {LEN0, LEN1, DATA, CHECK};

endmodule

// File: tb/tb_uart_boot_loader.sv
// Purpose: self-checking bench for uart_boot_loader; frames are built from word lists and expected writes/status derived from the frame rules.
// Latency: bytes are serialised at CPB cycles per bit with one idle bit between bytes.
// Backpressure: none.
module tb_uart_boot_loader;

   localparam int          CPB   = 12;
   localparam int          AW    = 4;
   localparam logic [7:0]  MAGIC = 8'hB5;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic        o_imemWrEn;
   logic [31:0] o_imemAddr;
   logic [31:0] o_imemWrData;
   logic        o_core_reset_n;
   logic        o_busy;
   logic        o_done;
   logic        o_error;

   always #5 clk = ~clk;

   uart_boot_loader #(
      .CLKS_PER_BIT(CPB),
      .ADDR_WIDTH  (AW),
      .MAGIC       (MAGIC),
      .BASE_ADDR   (BASE)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_rx          (rx),
      .o_imemWrEn    (o_imemWrEn),
      .o_imemAddr    (o_imemAddr),
      .o_imemWrData  (o_imemWrData),
      .o_core_reset_n(o_core_reset_n),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_error       (o_error)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   logic [31:0] obs_addr[$], obs_data[$], exp_addr[$], exp_data[$];
   logic [7:0]  frame_q[$];
   logic [31:0] wlist[$];
   int          dbl_pulse = 0;
   logic        prev_we = 1'b0;

   // Write-port monitor.
   always @(negedge clk) begin
      if (o_imemWrEn) begin
         obs_addr.push_back(o_imemAddr);
         obs_data.push_back(o_imemWrData);
         if (prev_we) dbl_pulse++;
      end
      prev_we = o_imemWrEn;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      obs_addr.delete();
      obs_data.delete();
      dbl_pulse = 0;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_wren"}, o_imemWrEn, 0);
      check({tag, "_addr"}, o_imemAddr, BASE);
      check({tag, "_data"}, o_imemWrData, 0);
      check({tag, "_corerst"}, o_core_reset_n, 0);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_done"}, o_done, 0);
      check({tag, "_err"}, o_error, 0);
   endtask

   task automatic reset_dut(input bit check_it, input string tag);
      rst_n = 1'b0;
      rx    = 1'b1;
      tick(2);
      @(negedge clk);
      if (check_it) check_reset_outs(tag);
      rst_n = 1'b1;
      tick(2);
      clear_obs();
      exp_addr.delete();
      exp_data.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = bad_stop ? 1'b0 : 1'b1;
      tick(CPB);
      rx = 1'b1;
      tick(CPB);
   endtask

   // Frame from wlist: MAGIC, LEN (LE), words (LE), XOR checksum.
   task automatic make_frame(input bit bad_chk);
      logic [15:0] n;
      logic [7:0]  c;
      logic [31:0] w;
      n = 16'(wlist.size());
      frame_q.delete();
      exp_addr.delete();
      exp_data.delete();
      frame_q.push_back(MAGIC);
      frame_q.push_back(n[7:0]);
      frame_q.push_back(n[15:8]);
      c = n[7:0] ^ n[15:8];
      for (int i = 0; i < wlist.size(); i++) begin
         w = wlist[i];
         for (int k = 0; k < 4; k++) begin
            frame_q.push_back(w[8*k +: 8]);
            c = c ^ w[8*k +: 8];
         end
         exp_addr.push_back(BASE + 32'(4 * i));
         exp_data.push_back(w);
      end
      frame_q.push_back(bad_chk ? (c ^ 8'h01) : c);
   endtask

   task automatic send_range(input int first, input int last, input int bad_idx);
      for (int i = first; i <= last; i++) send_byte(frame_q[i], i == bad_idx);
   endtask

   task automatic check_status(input string tag, input bit exp_done, input bit exp_err);
      @(negedge clk);
      check({tag, "_done"}, o_done, exp_done);
      check({tag, "_err"}, o_error, exp_err);
      check({tag, "_corerst"}, o_core_reset_n, exp_done);
      check({tag, "_busy"}, o_busy, 0);
   endtask

   task automatic check_writes(input string tag);
      int n;
      check({tag, "_nwr"}, obs_addr.size(), exp_addr.size());
      n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
         check($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
      end
      check({tag, "_pulsewidth"}, dbl_pulse, 0);
   endtask

   task automatic random_words(input int n);
      wlist.delete();
      for (int i = 0; i < n; i++) wlist.push_back($urandom);
   endtask

   initial begin
      int last;
      bit bad;

      // Reset state.
      reset_dut(1'b1, "rst");

      // Known two-word frame; CHK is C3.
      wlist = '{32'h0050_0093, 32'h0010_0113};
      make_frame(1'b0);
      last = frame_q.size() - 1;
      send_range(0, last - 1, -1);
      @(negedge clk);
      check("fix_prechk_busy", o_busy, 1);
      check("fix_prechk_done", o_done, 0);
      send_range(last, last, -1);
      check_status("fix", 1'b1, 1'b0);
      check_writes("fix");
      check("fix_addr_hold", o_imemAddr, 32'h4);
      check("fix_data_hold", o_imemWrData, 32'h0010_0113);

      // Bad checksum, then resend good.
      reset_dut(1'b0, "");
      make_frame(1'b1);
      send_range(0, frame_q.size() - 1, -1);
      check_status("badchk", 1'b0, 1'b1);
      check_writes("badchk");
      clear_obs();
      make_frame(1'b0);
      send_range(0, 0, -1);
      @(negedge clk);
      check("resend_magic_err", o_error, 0);
      check("resend_magic_busy", o_busy, 1);
      send_range(1, frame_q.size() - 1, -1);
      check_status("resend", 1'b1, 1'b0);
      check_writes("resend");

      // Junk bytes, a short low glitch, then an empty frame.
      reset_dut(1'b0, "");
      send_byte(8'h00, 1'b0);
      send_byte(8'hFF, 1'b0);
      send_byte(8'h3C, 1'b0);
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(2 * CPB);
      wlist.delete();
      make_frame(1'b0);
      send_range(0, frame_q.size() - 1, -1);
      check_status("glitch", 1'b1, 1'b0);
      check_writes("glitch");

      // Stop bit low on the third data byte: no writes at all.
      reset_dut(1'b0, "");
      wlist = '{32'h0050_0093, 32'h0010_0113};
      make_frame(1'b0);
      exp_addr.delete();
      exp_data.delete();
      send_range(0, frame_q.size() - 1, 5);
      check_status("stopbit", 1'b0, 1'b1);
      check_writes("stopbit");

      // Oversize lengths: 17 words, then 1025 words (limit 16).
      reset_dut(1'b0, "");
      send_byte(MAGIC, 1'b0);
      send_byte(8'h11, 1'b0);
      @(negedge clk);
      check("over17_len0_err", o_error, 0);
      send_byte(8'h00, 1'b0);
      check_status("over17", 1'b0, 1'b1);
      send_byte(MAGIC, 1'b0);
      send_byte(8'h01, 1'b0);
      @(negedge clk);
      check("over1025_len0_err", o_error, 0);
      send_byte(8'h04, 1'b0);
      check_status("over1025", 1'b0, 1'b1);
      check_writes("over");

      // Exactly the maximum image size.
      reset_dut(1'b0, "");
      random_words(1 << AW);
      make_frame(1'b0);
      send_range(0, frame_q.size() - 1, -1);
      check_status("max", 1'b1, 1'b0);
      check_writes("max");
      check("max_last_addr", o_imemAddr, BASE + 32'h3C);

      // One-cycle reset in the middle of the second data word.
      reset_dut(1'b0, "");
      wlist = '{32'h0050_0093, 32'h0010_0113};
      make_frame(1'b0);
      send_range(0, 8, -1);
      rx = 1'b0;
      tick(3 * CPB);
      rst_n = 1'b0;
      tick(1);
      @(negedge clk);
      check_reset_outs("midrst");
      rst_n = 1'b1;
      rx    = 1'b1;
      tick(2 * CPB);
      clear_obs();
      random_words(3);
      make_frame(1'b0);
      send_range(0, frame_q.size() - 1, -1);
      check_status("afterrst", 1'b1, 1'b0);
      check_writes("afterrst");

      // Random frames, some with a corrupted checksum.
      for (int k = 0; k < 3; k++) begin
         reset_dut(1'b0, "");
         random_words($urandom_range(1, 6));
         bad = 1'($urandom_range(0, 1));
         make_frame(bad);
         send_range(0, frame_q.size() - 1, -1);
         check_status($sformatf("rand%0d", k), !bad, bad);
         check_writes($sformatf("rand%0d", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
